freq_meter: RTL and testbench
=============================

// Module: freq_meter
// PURPOSE
//  Gated frequency counter: counts rising edges of an asynchronous input over a fixed
//  gate window timed by clk_in, and reports edges-per-window.
//  Complement of the clock dividers: measures a slow clock, e.g. a divider output or an
//  external pin, against the board oscillator (12 MHz on iCE40 HX8K breakout).
//  A 1 s gate gives the result directly in Hz.
// PARAMETERS
//  GATE_CYCLES  12000000  gate length in clk_in cycles (12E6 = 1 s at 12 MHz); >= 2
//  GATE_W       24        gate counter width; 2^GATE_W > GATE_CYCLES
//  CNT_W        24        edge counter / result width
// PORTS
//  clk_in    in   1      system clock
//  rst       in   1      asynchronous reset, active-high
//  sig_in    in   1      signal under measurement, asynchronous to clk_in
//  start     in   1      request one measurement; sampled in IDLE only
//  busy      out  1      1 while a gate window is open
//  freq_out  out  CNT_W  edge count of last completed window; held until next result
//  valid     out  1      one-cycle pulse when freq_out updates
//  ovf       out  1      last completed window saturated the edge counter
// BEHAVIOUR
//  - Clocking: one clock, clk_in. Reset rst is asynchronous and active-high.
//  - Reset: state IDLE; busy=0, freq_out=0, valid=0, ovf=0; all counters and sync FFs 0.
//  - sig_in: 2-FF synchroniser, then rising-edge detect (third FF), giving a 1-cycle
//    edge pulse. Pulse lags the pin by 2-3 cycles.
//  - Valid input range: sig_in high and low phases each >= 2 clk_in periods. Faster
//    inputs are not specified.
//  - States:
//    IDLE: start=1 -> GATE. gate_cnt=0, edge_cnt=0, busy<=1.
//    GATE: lasts exactly GATE_CYCLES cycles. gate_cnt counts 0..GATE_CYCLES-1.
//          Each edge pulse in those cycles adds 1 to edge_cnt, including the last cycle.
//          When gate_cnt==GATE_CYCLES-1 -> DONE.
//    DONE: one cycle. freq_out<=final count, ovf<=sat flag, valid=1, busy<=0 -> IDLE.
//  - Timing: start sampled at cycle 0 -> GATE during cycles 1..GATE_CYCLES.
//    valid=1 and new freq_out/ovf visible in cycle GATE_CYCLES+1.
//  - Saturation: edge_cnt stops at 2^CNT_W-1, never wraps; the window's sat flag is set.
//  - start while busy or in DONE: ignored, not queued.
//  - rst mid-window: immediate return to IDLE. No valid. freq_out/ovf cleared to 0.
//  - Width rule: gate_cnt compare is a GATE_W-bit equality against GATE_CYCLES-1.
// CONFIGURATION
//  FREQ_METER_AUTO_EN
//  - Undefined: single-shot, as above.
//  - Defined: continuous mode; start is ignored.
//    IDLE -> GATE unconditionally (first window starts in cycle 1 after rst deasserts).
//    DONE -> GATE directly, clearing both counters; IDLE is not revisited.
//    Results every GATE_CYCLES+1 cycles; the DONE cycle is dead time (edges not counted).
//    busy=0 only in DONE.
// STRUCTURE
//  - Shared include freq_meter_defs.vh (team package): state encodings
//    S_IDLE=2'd0, S_GATE=2'd1, S_DONE=2'd2; default GATE_CYCLES for 12 MHz/1 s;
//    CNT_MAX helper.
//  - One sub-module: sync_edge (2-FF sync + rising-edge pulse). Reusable for buttons and
//    other async pins.
//  - Top: FSM, gate counter, saturating edge counter, output registers.
// TESTING  (bench: GATE_CYCLES=100, GATE_W=8, CNT_W=8 unless noted)
//  1 rst asserted mid-run -> busy=0, valid=0, ovf=0, freq_out=0 same cycle (async).
//  2 sig_in period 10 clk (5 hi/5 lo), start 1 cycle -> busy for 100 cycles;
//    valid at cycle 101; freq_out=10; ovf=0.
//  3 sig_in held 0, then held 1, start -> freq_out=0 both runs; valid still pulses.
//  4 CNT_W=4, sig_in period 4 (25 edges/window) -> freq_out=15, ovf=1.
//    Next run with period 20 -> freq_out=5, ovf=0.
//  5 start pulsed at cycles 0, 50, 100 -> one measurement only, one valid at 101.
//    rst at cycle 60 of a second run -> no valid, freq_out=0.
//  6 FREQ_METER_AUTO_EN, sig_in period 10, no start -> valid every 101 cycles.
//    freq_out=10 each window (±1 allowed per window due to dead-cycle phase).

Source files
------------

// File: rtl/freq_meter_pkg.sv
// freq_meter_pkg: state encoding, default gate length and counter helper for freq_meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GATE = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // 12 MHz board oscillator, 1 s gate: result reads directly in Hz
    localparam int unsigned DEF_GATE_CYCLES = 12_000_000;

    function automatic logic [31:0] cnt_max(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : (32'd1 << w) - 32'd1;
    endfunction

endpackage

// File: rtl/freq_meter_sync_edge.sv
// freq_meter_sync_edge: 2-FF synchroniser plus rising-edge detect, one-cycle pulse per edge.
module freq_meter_sync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic pulse_o
);

    logic s1_q, s2_q, s3_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;

endmodule

// File: rtl/freq_meter.sv
// freq_meter: gated frequency counter, counts sig_in rising edges over GATE_CYCLES clk_in cycles.
// Define FREQ_METER_AUTO_EN for continuous back-to-back windows (start ignored).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEF_GATE_CYCLES,
    parameter int unsigned GATE_W      = 24,
    parameter int unsigned CNT_W       = 24
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             ovf
);

`ifdef FREQ_METER_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(cnt_max(CNT_W));
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              edge_p;
    logic              go;
    state_e            state_q;
    logic [GATE_W-1:0] gate_q;
    logic [CNT_W-1:0]  edge_q, edge_d, freq_q;
    logic              sat_q, sat_d, busy_q, valid_q, ovf_q;

    freq_meter_sync_edge u_sync (
        .clk_i  (clk_in),
        .rst_i  (rst),
        .d_i    (sig_in),
        .pulse_o(edge_p)
    );

    assign go = AUTO | start;

    // Saturate rather than wrap; sat records that at least one edge was lost
    always_comb begin
        edge_d = (edge_p && edge_q != CNT_MAX) ? edge_q + CNT_W'(1) : edge_q;
        sat_d  = sat_q | (edge_p & (edge_q == CNT_MAX));
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            freq_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        state_q <= S_GATE;
                        busy_q  <= 1'b1;
                    end
                end
                S_GATE: begin
                    edge_q <= edge_d;
                    sat_q  <= sat_d;
                    gate_q <= gate_q + GATE_W'(1);
                    if (gate_q == GATE_LAST) begin
                        state_q <= S_DONE;
                        freq_q  <= edge_d;
                        ovf_q   <= sat_d;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                S_DONE: begin
                    gate_q  <= '0;
                    edge_q  <= '0;
                    sat_q   <= 1'b0;
                    state_q <= AUTO ? S_GATE : S_IDLE;
                    busy_q  <= AUTO;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy     = busy_q;
    assign freq_out = freq_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized bench for freq_meter with an 8-bit and a 4-bit counter instance on shared stimulus.
module tb_freq_meter;

    localparam int GC = 100;

    logic       clk = 1'b0, rst = 1'b1, sig = 1'b0, start = 1'b0;
    logic       busy_a, valid_a, ovf_a, busy_b, valid_b, ovf_b;
    logic [7:0] freq_a;
    logic [3:0] freq_b;
    int         checks = 0, failures = 0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(8), .CNT_W(8)) dut_a (
        .clk_in(clk), .rst(rst), .sig_in(sig), .start(start),
        .busy(busy_a), .freq_out(freq_a), .valid(valid_a), .ovf(ovf_a)
    );

    freq_meter #(.GATE_CYCLES(GC), .GATE_W(8), .CNT_W(4)) dut_b (
        .clk_in(clk), .rst(rst), .sig_in(sig), .start(start),
        .busy(busy_b), .freq_out(freq_b), .valid(valid_b), .ovf(ovf_b)
    );

    function automatic bit pin_lvl(input int per, input int hi, input int off, input int c);
        return (per == 0) ? (hi != 0) : (((c + off + 1000) % per) < hi);
    endfunction

    // One single-shot measurement: start in cycle 0, pin pattern from cycle -8, observe to cycle GC+4
    task automatic run_window(input string name, input int per, input int hi, input int off,
                              input bit extra, input int exp_fixed);
        bit pins [0:GC+16];
        int n, busy_bad, valid_bad;
        n = 0; busy_bad = 0; valid_bad = 0;
        for (int c = -8; c <= GC + 4; c++) begin
            @(posedge clk); #1;
            if (c > -8) begin
                busy_bad += (busy_a !== (c >= 1 && c <= GC) || busy_b !== (c >= 1 && c <= GC)) ? 1 : 0;
                if (c != GC + 1) valid_bad += (valid_a !== 1'b0 || valid_b !== 1'b0) ? 1 : 0;
            end
            if (c == GC + 1) begin
                for (int j = -1; j <= GC - 2; j++) n += (pins[j+8] && !pins[j+7]) ? 1 : 0;
                checks += 6;
                if (valid_a !== 1'b1) begin failures++; $display("FAIL %s valid_a: got %0b expected 1", name, valid_a); end
                if (valid_b !== 1'b1) begin failures++; $display("FAIL %s valid_b: got %0b expected 1", name, valid_b); end
                if (freq_a !== 8'((n > 255) ? 255 : n)) begin failures++; $display("FAIL %s freq_a: got %0d expected %0d", name, freq_a, (n > 255) ? 255 : n); end
                if (ovf_a !== (n > 255)) begin failures++; $display("FAIL %s ovf_a: got %0b expected %0b", name, ovf_a, n > 255); end
                if (freq_b !== 4'((n > 15) ? 15 : n)) begin failures++; $display("FAIL %s freq_b: got %0d expected %0d", name, freq_b, (n > 15) ? 15 : n); end
                if (ovf_b !== (n > 15)) begin failures++; $display("FAIL %s ovf_b: got %0b expected %0b", name, ovf_b, n > 15); end
                if (exp_fixed >= 0) begin
                    checks++;
                    if (int'(freq_a) != exp_fixed) begin failures++; $display("FAIL %s freq_fixed: got %0d expected %0d", name, freq_a, exp_fixed); end
                end
            end
            sig = pin_lvl(per, hi, off, c);
            pins[c+8] = sig;
            start = (c == 0) || (extra && (c == 50 || c == GC || c == GC + 1));
        end
        start = 1'b0;
        checks += 2;
        if (busy_bad != 0) begin failures++; $display("FAIL %s busy_window: got %0d bad cycles expected 0", name, busy_bad); end
        if (valid_bad != 0) begin failures++; $display("FAIL %s valid_single: got %0d stray valid cycles expected 0", name, valid_bad); end
    endtask

    task automatic test_reset;
        checks += 4;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL reset busy: got %0b expected 0", busy_a); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL reset valid: got %0b expected 0", valid_a); end
        if (freq_a !== 8'd0) begin failures++; $display("FAIL reset freq: got %0d expected 0", freq_a); end
        if (ovf_b !== 1'b0) begin failures++; $display("FAIL reset ovf: got %0b expected 0", ovf_b); end
    endtask

    task automatic test_basic;
        run_window("basic_p10", 10, 5, int'($urandom % 10), 1'b0, 10);
    endtask

    task automatic test_const;
        run_window("const_low", 0, 0, 0, 1'b0, 0);
        run_window("const_high", 0, 1, 0, 1'b0, 0);
    endtask

    task automatic test_saturate;
        run_window("sat_p4", 4, 2, int'($urandom % 4), 1'b0, 25);
        run_window("sat_p20", 20, 10, int'($urandom % 20), 1'b0, 5);
    endtask

    task automatic test_start_ignored;
        run_window("start_ignored", 10, 5, int'($urandom % 10), 1'b1, 10);
    endtask

    task automatic test_random;
        int per;
        for (int i = 0; i < 6; i++) begin
            per = 4 + int'($urandom % 37);
            run_window("random", per, 2 + int'($urandom % (per - 3)), int'($urandom % per), 1'b0, -1);
        end
    endtask

    task automatic test_reset_mid;
        int valid_bad;
        valid_bad = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            sig = pin_lvl(10, 5, 0, c);
            start = (c == 0);
        end
        @(posedge clk); #1;
        checks++;
        if (busy_a !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %0b expected 1", busy_a); end
        rst = 1'b1;
        #1;
        checks += 5;
        if (busy_a !== 1'b0) begin failures++; $display("FAIL mid_rst busy: got %0b expected 0", busy_a); end
        if (valid_a !== 1'b0) begin failures++; $display("FAIL mid_rst valid: got %0b expected 0", valid_a); end
        if (freq_a !== 8'd0) begin failures++; $display("FAIL mid_rst freq_a: got %0d expected 0", freq_a); end
        if (ovf_a !== 1'b0) begin failures++; $display("FAIL mid_rst ovf: got %0b expected 0", ovf_a); end
        if (freq_b !== 4'd0) begin failures++; $display("FAIL mid_rst freq_b: got %0d expected 0", freq_b); end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(posedge clk); #1;
            sig = pin_lvl(10, 5, 0, c);
            valid_bad += (valid_a !== 1'b0 || busy_a !== 1'b0) ? 1 : 0;
        end
        checks += 2;
        if (valid_bad != 0) begin failures++; $display("FAIL mid_rst idle_after: got %0d active cycles expected 0", valid_bad); end
        if (freq_a !== 8'd0) begin failures++; $display("FAIL mid_rst freq_after: got %0d expected 0", freq_a); end
    endtask

    task automatic test_auto;
        int bad;
        bad = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        sig = pin_lvl(10, 5, 3, 0);
        for (int c = 1; c <= 3 * (GC + 1) + 2; c++) begin
            @(posedge clk); #1;
            if (c % (GC + 1) == 0) begin
                checks += 3;
                if (valid_a !== 1'b1) begin failures++; $display("FAIL auto valid: got %0b expected 1 at cycle %0d", valid_a, c); end
                if (freq_a < 8'd9 || freq_a > 8'd11) begin failures++; $display("FAIL auto freq: got %0d expected 9..11", freq_a); end
                if (busy_a !== 1'b0) begin failures++; $display("FAIL auto busy_done: got %0b expected 0", busy_a); end
            end else begin
                bad += (valid_a !== 1'b0 || busy_a !== 1'b1) ? 1 : 0;
            end
            sig = pin_lvl(10, 5, 3, c);
        end
        checks++;
        if (bad != 0) begin failures++; $display("FAIL auto gate_cycles: got %0d bad cycles expected 0", bad); end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        test_reset;
`ifdef FREQ_METER_AUTO_EN
        test_auto;
`else
        @(posedge clk); #1;
        rst = 1'b0;
        test_basic;
        test_const;
        test_saturate;
        test_start_ignored;
        test_random;
        test_reset_mid;
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
